// File: rtl/xif_mem_pkg.sv
// Shared types for the X-interface memory responder: request/response records,
// id FIFO entry and access-size encoding.
package xif_mem_pkg;

    // Storage width for instruction ids; the responder zero-extends its ID_WIDTH ids into it.
    localparam int unsigned ID_MAX_W = 16;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic [31:0]         addr;
        logic                we;
        logic [1:0]          size;
        logic [3:0]          be;
        logic [31:0]         wdata;
        logic [ID_MAX_W-1:0] id;
    } mem_req_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [31:0]         rdata;
        logic                err;
    } mem_resp_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic                we;
    } id_fifo_entry_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/xif_mem_id_fifo.sv
// In-order FIFO of {id, we} for granted OBI transactions awaiting their response.
// Latency: head visible the cycle after push; push+pop allowed in one cycle, even when full.
// Backpressure: push dropped when full without a pop, pop ignored when empty.
module xif_mem_id_fifo
    import xif_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           push_i,
    input  id_fifo_entry_t push_dat_i,
    input  logic           pop_i,
    output id_fifo_entry_t head_dat_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    id_fifo_entry_t   mem_q [DEPTH];
    id_fifo_entry_t   mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/xif_mem_responder.sv
// Bridges CV-X-IF mem requests onto an OBI data master and returns in-order tagged results.
// Latency: handshake -> OBI req next cycle, result one cycle after rvalid; ready stalls at MAX_OUTSTANDING.
// XIF_MEM_ALIGN_CHECK_EN: misaligned requests are answered locally with err=1 instead of reaching OBI.
module xif_mem_responder
    import xif_mem_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_WIDTH        = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                x_mem_valid_i,
    output logic                x_mem_ready_o,
    input  logic [31:0]         x_mem_req_addr_i,
    input  logic                x_mem_req_we_i,
    input  logic [1:0]          x_mem_req_size_i,
    input  logic [3:0]          x_mem_req_be_i,
    input  logic [31:0]         x_mem_req_wdata_i,
    input  logic [ID_WIDTH-1:0] x_mem_req_id_i,
    input  logic                x_mem_req_spec_i,
    input  logic                x_mem_req_last_i,
    output logic                x_mem_result_valid_o,
    output logic [ID_WIDTH-1:0] x_mem_result_id_o,
    output logic [31:0]         x_mem_result_rdata_o,
    output logic                x_mem_result_err_o,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    output logic [3:0]          data_be_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic                data_err_i,
    input  logic [31:0]         data_rdata_i,
    output logic                lsu_busy_o
);

    localparam int unsigned CNT_W = 3;

    logic             pending_q, pending_d;
    mem_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_vld_q, resp_vld_d;
    mem_resp_t        resp_q, resp_d;

    logic             hs, misaligned, gnt_push, rsp_pop;
    logic             fifo_full, fifo_empty;
    id_fifo_entry_t   fifo_head, fifo_in;
    logic             unused_ok;

`ifdef XIF_MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(x_mem_req_size_i, x_mem_req_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // A misaligned request may only be answered once the bus is drained, otherwise it would overtake.
    assign x_mem_ready_o = ~pending_q & (cnt_q < CNT_W'(MAX_OUTSTANDING))
                         & (~misaligned | (cnt_q == '0));
    assign hs       = x_mem_valid_i & x_mem_ready_o;
    assign gnt_push = pending_q & data_gnt_i;
    assign rsp_pop  = data_rvalid_i & ~fifo_empty;
    assign fifo_in  = '{id: req_q.id, we: req_q.we};

    xif_mem_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (gnt_push),
        .push_dat_i (fifo_in),
        .pop_i      (rsp_pop),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        pending_d  = pending_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        resp_vld_d = 1'b0;
        resp_d     = '0;

        if (gnt_push) begin
            pending_d = 1'b0;
        end
        if (hs && !misaligned) begin
            pending_d   = 1'b1;
            req_d.addr  = x_mem_req_addr_i;
            req_d.we    = x_mem_req_we_i;
            req_d.size  = x_mem_req_size_i;
            req_d.be    = x_mem_req_be_i;
            req_d.wdata = x_mem_req_wdata_i;
            req_d.id    = ID_MAX_W'(x_mem_req_id_i);
        end

        case ({gnt_push, rsp_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (rsp_pop) begin
            resp_vld_d   = 1'b1;
            resp_d.id    = fifo_head.id;
            resp_d.rdata = fifo_head.we ? 32'h0 : data_rdata_i;
            resp_d.err   = data_err_i;
        end else if (hs && misaligned) begin
            resp_vld_d   = 1'b1;
            resp_d.id    = ID_MAX_W'(x_mem_req_id_i);
            resp_d.err   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q  <= 1'b0;
            req_q      <= '0;
            cnt_q      <= '0;
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            resp_vld_q <= resp_vld_d;
            resp_q     <= resp_d;
        end
    end

    assign data_req_o           = pending_q;
    assign data_we_o            = req_q.we;
    assign data_addr_o          = req_q.addr;
    assign data_wdata_o         = req_q.wdata;
    assign data_be_o            = req_q.be;
    assign x_mem_result_valid_o = resp_vld_q;
    assign x_mem_result_id_o    = resp_q.id[ID_WIDTH-1:0];
    assign x_mem_result_rdata_o = resp_q.rdata;
    assign x_mem_result_err_o   = resp_q.err;
    assign lsu_busy_o           = pending_q | (cnt_q != '0) | resp_vld_q;

    // Speculation/last hints are meaningless for a single non-speculative access.
    assign unused_ok = ^{x_mem_req_spec_i, x_mem_req_last_i, req_q.size, resp_q.id, fifo_full};

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder: OBI slave driven step by step, results checked
// against a queue of expected {id, rdata, err} pushed as each response is stimulated.
module tb_xif_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_mem_valid_i, x_mem_ready_o;
    logic [31:0] x_mem_req_addr_i, x_mem_req_wdata_i;
    logic        x_mem_req_we_i;
    logic [1:0]  x_mem_req_size_i;
    logic [3:0]  x_mem_req_be_i;
    logic [3:0]  x_mem_req_id_i;
    logic        x_mem_req_spec_i, x_mem_req_last_i;
    logic        x_mem_result_valid_o;
    logic [3:0]  x_mem_result_id_o;
    logic [31:0] x_mem_result_rdata_o;
    logic        x_mem_result_err_o;
    logic        data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        lsu_busy_o;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    xif_mem_responder #(.MAX_OUTSTANDING(2), .ID_WIDTH(4)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .x_mem_valid_i        (x_mem_valid_i),
        .x_mem_ready_o        (x_mem_ready_o),
        .x_mem_req_addr_i     (x_mem_req_addr_i),
        .x_mem_req_we_i       (x_mem_req_we_i),
        .x_mem_req_size_i     (x_mem_req_size_i),
        .x_mem_req_be_i       (x_mem_req_be_i),
        .x_mem_req_wdata_i    (x_mem_req_wdata_i),
        .x_mem_req_id_i       (x_mem_req_id_i),
        .x_mem_req_spec_i     (x_mem_req_spec_i),
        .x_mem_req_last_i     (x_mem_req_last_i),
        .x_mem_result_valid_o (x_mem_result_valid_o),
        .x_mem_result_id_o    (x_mem_result_id_o),
        .x_mem_result_rdata_o (x_mem_result_rdata_o),
        .x_mem_result_err_o   (x_mem_result_err_o),
        .data_req_o           (data_req_o),
        .data_we_o            (data_we_o),
        .data_addr_o          (data_addr_o),
        .data_wdata_o         (data_wdata_o),
        .data_be_o            (data_be_o),
        .data_gnt_i           (data_gnt_i),
        .data_rvalid_i        (data_rvalid_i),
        .data_err_i           (data_err_i),
        .data_rdata_i         (data_rdata_i),
        .lsu_busy_o           (lsu_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                             input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] id);
        x_mem_valid_i     = 1'b1;
        x_mem_req_addr_i  = addr;
        x_mem_req_we_i    = we;
        x_mem_req_size_i  = size;
        x_mem_req_be_i    = be;
        x_mem_req_wdata_i = wdata;
        x_mem_req_id_i    = id;
    endtask

    task automatic expect_result(input logic [3:0] id, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.id = id; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    // Result monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (x_mem_result_valid_o) begin
            if (exp_q.size() == 0) begin
                check("sb_stray_result", x_mem_result_valid_o, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", {x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o},
                      {e.id, e.rdata, e.err});
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        x_mem_valid_i = 1'b0; x_mem_req_addr_i = '0; x_mem_req_we_i = 1'b0;
        x_mem_req_size_i = 2'd2; x_mem_req_be_i = '0; x_mem_req_wdata_i = '0;
        x_mem_req_id_i = '0; x_mem_req_spec_i = 1'b0; x_mem_req_last_i = 1'b1;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
        tick(); tick();

        // Reset state
        check("rst_ready", x_mem_ready_o, 1'b1);
        check("rst_obi_ctl", {data_req_o, data_we_o, data_be_o}, '0);
        check("rst_obi_dat", {data_addr_o, data_wdata_o}, '0);
        check("rst_result", {x_mem_result_valid_o, x_mem_result_id_o, x_mem_result_rdata_o,
                             x_mem_result_err_o}, '0);
        check("rst_busy", lsu_busy_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Load id 3, gnt in the first request cycle, rvalid next
        drive_req(32'h100, 1'b0, 2'd2, 4'hF, 32'h0, 4'd3);
        tick();
        x_mem_valid_i = 1'b0;
        check("t1_req", {data_req_o, data_we_o, data_be_o}, {1'b1, 1'b0, 4'hF});
        check("t1_addr", data_addr_o, 32'h100);
        data_gnt_i = 1'b1;
        expect_result(4'd3, 32'hDEADBEEF, 1'b0);
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
        check("t1_no_early_result", x_mem_result_valid_o, 1'b0);
        tick();
        data_rvalid_i = 1'b0;
        check("t1_res_vld", x_mem_result_valid_o, 1'b1);
        tick();

        // Store id 5, grant held off 4 cycles: request fields stay stable
        drive_req(32'h200, 1'b1, 2'd2, 4'b0110, 32'hA5A5_1234, 4'd5);
        tick();
        x_mem_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_stable_dat", {data_addr_o, data_wdata_o}, {32'h200, 32'hA5A5_1234});
            check("t2_stable_ctl", {data_req_o, data_we_o, data_be_o}, {1'b1, 1'b1, 4'b0110});
            tick();
        end
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        check("t2_req_drop", data_req_o, 1'b0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
        expect_result(4'd5, 32'h0, 1'b0);
        tick();
        data_rvalid_i = 1'b0;
        check("t2_busy_result", lsu_busy_o, 1'b1);
        tick();
        check("t2_idle", lsu_busy_o, 1'b0);

        // Three loads against two outstanding slots, responses withheld
        data_gnt_i = 1'b1;
        drive_req(32'h300, 1'b0, 2'd2, 4'hF, 32'h0, 4'd1);
        tick();
        x_mem_valid_i = 1'b0;
        tick();
        drive_req(32'h304, 1'b0, 2'd2, 4'hF, 32'h0, 4'd2);
        check("t3_ready_one_out", x_mem_ready_o, 1'b1);
        tick();
        drive_req(32'h308, 1'b0, 2'd2, 4'hF, 32'h0, 4'd3);
        check("t3_ready_pending", x_mem_ready_o, 1'b0);
        tick();
        check("t3_ready_full", x_mem_ready_o, 1'b0);
        check("t3_no_req_full", data_req_o, 1'b0);
        tick();
        check("t3_ready_full2", x_mem_ready_o, 1'b0);
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_0001;
        expect_result(4'd1, 32'h1111_0001, 1'b0);
        tick();
        data_rvalid_i = 1'b0;
        check("t3_ready_freed", x_mem_ready_o, 1'b1);
        tick();
        x_mem_valid_i = 1'b0;
        check("t3_third_req", {data_req_o, data_addr_o}, {1'b1, 32'h308});
        data_rvalid_i = 1'b1; data_rdata_i = 32'h2222_0002;
        expect_result(4'd2, 32'h2222_0002, 1'b0);
        tick();
        data_rdata_i = 32'h3333_0003;
        expect_result(4'd3, 32'h3333_0003, 1'b0);
        check("t3_ready_after_swap", x_mem_ready_o, 1'b1);
        tick();
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
        tick();
        check("t3_idle", lsu_busy_o, 1'b0);

        // Bus error propagates; a stray rvalid produces nothing
        drive_req(32'h400, 1'b0, 2'd2, 4'hF, 32'h0, 4'd7);
        tick();
        x_mem_valid_i = 1'b0;
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_err_i = 1'b1; data_rdata_i = 32'h0BAD;
        expect_result(4'd7, 32'h0BAD, 1'b1);
        tick();
        data_err_i = 1'b0; data_rdata_i = 32'h5555_AAAA;
        tick();
        data_rvalid_i = 1'b0;
        check("t4_stray_ignored", x_mem_result_valid_o, 1'b0);
        check("t4_idle", lsu_busy_o, 1'b0);

        // Misaligned word load
        drive_req(32'h102, 1'b0, 2'd2, 4'hF, 32'h0, 4'd9);
`ifdef XIF_MEM_ALIGN_CHECK_EN
        expect_result(4'd9, 32'h0, 1'b1);
        tick();
        x_mem_valid_i = 1'b0;
        check("t5_no_obi", data_req_o, 1'b0);
        check("t5_err_pulse", {x_mem_result_valid_o, x_mem_result_err_o}, 2'b11);
        tick();
`else
        tick();
        x_mem_valid_i = 1'b0;
        check("t5_obi_unaligned", {data_req_o, data_addr_o}, {1'b1, 32'h102});
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        expect_result(4'd9, 32'hCAFE_F00D, 1'b0);
        tick();
        data_rvalid_i = 1'b0;
        tick();
`endif

        // Reset with two transactions outstanding
        data_gnt_i = 1'b1;
        drive_req(32'h600, 1'b0, 2'd2, 4'hF, 32'h0, 4'd10);
        tick();
        x_mem_valid_i = 1'b0;
        tick();
        drive_req(32'h604, 1'b0, 2'd2, 4'hF, 32'h0, 4'd11);
        tick();
        x_mem_valid_i = 1'b0;
        tick();
        data_gnt_i = 1'b0;
        check("t6_two_out", {lsu_busy_o, x_mem_ready_o}, 2'b10);
        rst_ni = 1'b0;
        tick();
        check("t6_rst_ready", x_mem_ready_o, 1'b1);
        check("t6_rst_obi", {data_req_o, data_addr_o, data_wdata_o}, '0);
        check("t6_rst_busy", lsu_busy_o, 1'b0);
        rst_ni = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h7777_7777;
        tick();
        tick();
        data_rvalid_i = 1'b0;
        check("t6_late_rvalid", x_mem_result_valid_o, 1'b0);
        tick();
        check("t6_idle", lsu_busy_o, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
